// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken-branch
// flush and the multi-cycle mult/div handshake with a watchdog.
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inFD,
  input  logic [31:0] inDX,
  input  logic        branchTaken,
  input  logic        multdivRDY,
  input  logic        multdivException,
  output logic        stallPC,
  output logic        stallFD,
  output logic        stallDX,
  output logic        bubbleDX,
  output logic        flushFD,
  output logic        bubbleXM,
  output logic        ctrlMult,
  output logic        ctrlDiv,
  output logic        mdDone,
  output logic        mdException,
  output logic        mdTimeout
);

  localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } mdState_e;

  mdState_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exc_q, exc_d;
  logic          timeout_q, timeout_d;

  logic [4:0] opFD, rdFD, rsFD, rtFD, aluFD;
  logic [4:0] opDX, rdDX, aluDX;
  logic       fdReadsRs, fdReadsRt, fdReadsRd;
  logic       dxIsMul, dxIsDiv, loadUse;

  assign opFD  = inFD[31:27];
  assign rdFD  = inFD[26:22];
  assign rsFD  = inFD[21:17];
  assign rtFD  = inFD[16:12];
  assign aluFD = inFD[6:2];
  assign opDX  = inDX[31:27];
  assign rdDX  = inDX[26:22];
  assign aluDX = inDX[6:2];

  assign fdReadsRs = !(opFD == OP_J || opFD == OP_JAL || opFD == OP_SETX || opFD == OP_BEX);
  assign fdReadsRt = (opFD == OP_R) && (aluFD != ALU_SLL) && (aluFD != ALU_SRA);
  assign fdReadsRd = (opFD == OP_SW) || (opFD == OP_BNE) || (opFD == OP_BLT) || (opFD == OP_JR);

  assign dxIsMul = (opDX == OP_R) && (aluDX == ALU_MUL);
  assign dxIsDiv = (opDX == OP_R) && (aluDX == ALU_DIV);

  // r0 is hardwired, so a load into it never creates a dependency.
  assign loadUse = (opDX == OP_LW) && (rdDX != 5'd0) &&
                   ((fdReadsRs && rsFD == rdDX) ||
                    (fdReadsRt && rtFD == rdDX) ||
                    (fdReadsRd && rdFD == rdDX) ||
                    (opFD == OP_BEX && rdDX == 5'd30));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exc_q     <= exc_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    logic mdStall;
    state_d     = state_q;
    cnt_d       = cnt_q;
    exc_d       = exc_q;
    timeout_d   = timeout_q;
    mdStall     = 1'b0;
    stallPC     = 1'b0;
    stallFD     = 1'b0;
    stallDX     = 1'b0;
    bubbleDX    = 1'b0;
    flushFD     = 1'b0;
    bubbleXM    = 1'b0;
    ctrlMult    = 1'b0;
    ctrlDiv     = 1'b0;
    mdDone      = 1'b0;
    mdException = 1'b0;
    mdTimeout   = timeout_q;

    unique case (state_q)
      MD_IDLE: begin
        if (dxIsMul || dxIsDiv) begin
          state_d  = MD_BUSY;
          cnt_d    = '0;
          exc_d    = 1'b0;
          mdStall  = 1'b1;
          ctrlMult = dxIsMul;
          ctrlDiv  = dxIsDiv;
        end
      end
      MD_BUSY: begin
        mdStall = 1'b1;
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        // A result arriving on the watchdog's last cycle still counts as success.
        if (multdivRDY) begin
          state_d = MD_DONE;
          exc_d   = multdivException;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = MD_DONE;
          exc_d     = 1'b1;
          timeout_d = 1'b1;
        end
      end
      MD_DONE: begin
        state_d     = MD_IDLE;
        mdDone      = 1'b1;
        mdException = exc_q;
      end
      default: state_d = MD_IDLE;
    endcase

    if (mdStall) begin
      stallPC  = 1'b1;
      stallFD  = 1'b1;
      stallDX  = 1'b1;
      bubbleXM = 1'b1;
    end else if (branchTaken) begin
      flushFD  = 1'b1;
      bubbleDX = 1'b1;
    end else if (loadUse) begin
      stallPC  = 1'b1;
      stallFD  = 1'b1;
      bubbleDX = 1'b1;
    end

    if (reset) begin
      stallPC     = 1'b0;
      stallFD     = 1'b0;
      stallDX     = 1'b0;
      bubbleDX    = 1'b0;
      flushFD     = 1'b0;
      bubbleXM    = 1'b0;
      ctrlMult    = 1'b0;
      ctrlDiv     = 1'b0;
      mdDone      = 1'b0;
      mdException = 1'b0;
      mdTimeout   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed hazard table,
// mult/div transaction checks and randomized comparison against a rule-level model.
module tb_pipeline_stall_controller;

  localparam int MD_TIMEOUT = 8;

  localparam logic [4:0] OP_R = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010, OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR = 5'b00100, OP_ADDI = 5'b00101, OP_BLT = 5'b00110, OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000, OP_SETX = 5'b10101, OP_BEX = 5'b10110;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inFD, inDX;
  logic        branchTaken, multdivRDY, multdivException;
  logic        stallPC, stallFD, stallDX, bubbleDX, flushFD, bubbleXM;
  logic        ctrlMult, ctrlDiv, mdDone, mdException, mdTimeout;
  logic [10:0] outs;

  int passCount = 0;
  int checkCount = 0;
  bit mdlTimeout = 1'b0;

  always #5 clock = ~clock;

  pipeline_stall_controller #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .inFD(inFD), .inDX(inDX),
    .branchTaken(branchTaken), .multdivRDY(multdivRDY), .multdivException(multdivException),
    .stallPC(stallPC), .stallFD(stallFD), .stallDX(stallDX), .bubbleDX(bubbleDX),
    .flushFD(flushFD), .bubbleXM(bubbleXM), .ctrlMult(ctrlMult), .ctrlDiv(ctrlDiv),
    .mdDone(mdDone), .mdException(mdException), .mdTimeout(mdTimeout)
  );

  assign outs = {stallPC, stallFD, stallDX, bubbleDX, flushFD, bubbleXM,
                 ctrlMult, ctrlDiv, mdDone, mdException, mdTimeout};

  typedef struct {
    string       name;
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] mkR(input int rd, input int rs, input int rt, input int sh, input int alu);
    return {OP_R, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(alu), 2'b00};
  endfunction

  function automatic logic [31:0] mkI(input logic [4:0] op, input int rd, input int rs, input int imm);
    return {op, 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  // Set of registers an instruction in F/D reads, as a 32-bit membership mask.
  function automatic logic [31:0] readMask(input logic [31:0] ins);
    logic [31:0] m;
    logic [4:0]  op, alu;
    op  = ins[31:27];
    alu = ins[6:2];
    m   = '0;
    if (!(op inside {OP_J, OP_JAL, OP_SETX, OP_BEX})) m[ins[21:17]] = 1'b1;
    if (op == OP_R && alu != 5'b00100 && alu != 5'b00101) m[ins[16:12]] = 1'b1;
    if (op inside {OP_SW, OP_BNE, OP_BLT, OP_JR}) m[ins[26:22]] = 1'b1;
    if (op == OP_BEX) m[30] = 1'b1;
    return m;
  endfunction

  // Expected {stallPC,stallFD,stallDX,bubbleDX,flushFD,bubbleXM,ctrlMult,ctrlDiv} while idle.
  function automatic logic [7:0] hazardModel(input logic [31:0] fd, input logic [31:0] dx, input logic br);
    logic [31:0] m;
    m = readMask(fd);
    if (br) return 8'b0001_1000;
    if (dx[31:27] == OP_LW && dx[26:22] != 5'd0 && m[dx[26:22]]) return 8'b1101_0000;
    return 8'b0000_0000;
  endfunction

  function automatic logic [4:0] pickReg();
    if ($urandom_range(0, 9) == 0) return 5'd30;
    return 5'($urandom_range(0, 4));
  endfunction

  function automatic logic [31:0] randInstr(input bit allowMd);
    logic [4:0] op, alu;
    case ($urandom_range(0, 10))
      0: op = OP_R;    1: op = OP_J;   2: op = OP_BNE;  3: op = OP_JAL;
      4: op = OP_JR;   5: op = OP_ADDI; 6: op = OP_BLT; 7: op = OP_SW;
      8: op = OP_LW;   9: op = OP_SETX; default: op = OP_BEX;
    endcase
    alu = 5'($urandom_range(0, 7));
    if (!allowMd && op == OP_R && (alu == 5'd6 || alu == 5'd7)) alu = 5'd0;
    return {op, pickReg(), pickReg(), pickReg(), 5'($urandom_range(0, 31)), alu, 2'b00};
  endfunction

  task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                               input logic rdy, input logic exc);
    @(negedge clock);
    inFD = fd;
    inDX = dx;
    branchTaken = br;
    multdivRDY = rdy;
    multdivException = exc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
  endtask

  // One mult/div transaction; lat = BUSY cycle on which RDY arrives (0 or > MD_TIMEOUT: never).
  task automatic runMd(input bit isDiv, input int lat, input bit exc, input string tag);
    int expBusy, expStall, ctrlM, ctrlD, stallCnt, doneCnt, doneAt, bad, excAtDone;
    bit expTo, expExc, rdy, allStall, anyStall;
    logic [31:0] mdI;
    expTo    = !(lat >= 1 && lat <= MD_TIMEOUT);
    expBusy  = expTo ? MD_TIMEOUT : lat;
    expExc   = expTo ? 1'b1 : exc;
    expStall = 1 + expBusy;
    mdI = mkR($urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, isDiv ? 7 : 6);
    ctrlM = 0; ctrlD = 0; stallCnt = 0; doneCnt = 0; doneAt = -1; bad = 0; excAtDone = 0;
    for (int i = 0; i <= expStall + 3; i++) begin
      rdy = (i >= 1 && i == lat);
      applyStimulus(randInstr(1), (i <= expStall) ? mdI : 32'h0,
                    (i >= 1 && i < expStall) ? 1'($urandom_range(0, 1)) : 1'b0,
                    rdy, rdy ? exc : 1'($urandom_range(0, 1)));
      if (ctrlMult) ctrlM++;
      if (ctrlDiv) ctrlD++;
      allStall = stallPC && stallFD && stallDX && bubbleXM;
      anyStall = stallPC || stallFD || stallDX || bubbleXM;
      if (allStall) begin
        stallCnt++;
        if (flushFD || bubbleDX || i >= expStall) bad++;
      end else if (anyStall) bad++;
      if (mdDone) begin
        doneCnt++;
        doneAt = i;
        excAtDone = int'(mdException);
      end
    end
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    mdlTimeout = mdlTimeout | expTo;
    checkOutput({tag, " ctrlMult pulses"}, ctrlM, isDiv ? 0 : 1);
    checkOutput({tag, " ctrlDiv pulses"}, ctrlD, isDiv ? 1 : 0);
    checkOutput({tag, " stall cycles"}, stallCnt, expStall);
    checkOutput({tag, " stray stall/flush"}, bad, 0);
    checkOutput({tag, " mdDone count"}, doneCnt, 1);
    checkOutput({tag, " mdDone cycle"}, doneAt, expStall);
    checkOutput({tag, " mdException"}, excAtDone, int'(expExc));
    checkOutput({tag, " mdTimeout flag"}, mdTimeout, mdlTimeout);
  endtask

  initial begin
    logic [31:0] fd, dx;
    logic        br;
    int          leaks;

    vecs[0]  = '{"lw r3 / add uses rs", mkR(4, 3, 2, 0, 0), mkI(OP_LW, 3, 1, 0), 1'b0, 8'b1101_0000};
    vecs[1]  = '{"lw r0 no stall", mkR(4, 0, 2, 0, 0), mkI(OP_LW, 0, 1, 0), 1'b0, 8'b0000_0000};
    vecs[2]  = '{"lw r5 / sw reads rd", mkI(OP_SW, 5, 2, 0), mkI(OP_LW, 5, 1, 0), 1'b0, 8'b1101_0000};
    vecs[3]  = '{"lw r5 / sll rt=5", mkR(6, 7, 5, 2, 4), mkI(OP_LW, 5, 1, 0), 1'b0, 8'b0000_0000};
    vecs[4]  = '{"branch beats load-use", mkR(4, 3, 2, 0, 0), mkI(OP_LW, 3, 1, 0), 1'b1, 8'b0001_1000};
    vecs[5]  = '{"lw r30 / bex", mkI(OP_BEX, 0, 3, 0), mkI(OP_LW, 30, 1, 0), 1'b0, 8'b1101_0000};
    vecs[6]  = '{"lw r3 / bex rs field", mkI(OP_BEX, 0, 3, 0), mkI(OP_LW, 3, 1, 0), 1'b0, 8'b0000_0000};
    vecs[7]  = '{"lw r2 / add uses rt", mkR(4, 3, 2, 0, 0), mkI(OP_LW, 2, 1, 0), 1'b0, 8'b1101_0000};
    vecs[8]  = '{"lw r4 / jr r4", mkI(OP_JR, 4, 0, 0), mkI(OP_LW, 4, 1, 0), 1'b0, 8'b1101_0000};
    vecs[9]  = '{"lw r1 / j rs field", mkI(OP_J, 0, 1, 0), mkI(OP_LW, 1, 1, 0), 1'b0, 8'b0000_0000};
    vecs[10] = '{"add in DX no stall", mkR(4, 3, 2, 0, 0), mkR(3, 1, 1, 0, 0), 1'b0, 8'b0000_0000};
    vecs[11] = '{"lw r7 / sra rt=7", mkR(1, 2, 7, 3, 5), mkI(OP_LW, 7, 1, 0), 1'b0, 8'b0000_0000};

    reset = 1'b1; inFD = '0; inDX = '0; branchTaken = 1'b0; multdivRDY = 1'b0; multdivException = 1'b0;
    repeat (2) @(negedge clock);
    #1 checkOutput("outputs during reset", outs, 0);
    @(negedge clock);
    reset = 1'b0;
    #1 checkOutput("reset state idle", outs, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].fd, vecs[i].dx, vecs[i].br, 1'b0, 1'b0);
      checkOutput(vecs[i].name, outs, {vecs[i].exp, 3'b000});
    end
    applyStimulus(mkR(4, 3, 2, 0, 0), 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("noop after load-use", outs, 0);

    runMd(1'b0, 5, 1'b0, "mul rdy@5");
    runMd(1'b1, 3, 1'b1, "div exception");
    runMd(1'b0, MD_TIMEOUT, 1'b0, "rdy on last cycle");
    runMd(1'b1, 0, 1'b0, "div timeout");
    runMd(1'b0, 2, 1'b0, "mul after timeout");
    for (int r = 0; r < 6; r++)
      runMd(1'($urandom_range(0, 1)), $urandom_range(1, MD_TIMEOUT + 3), 1'($urandom_range(0, 1)), "random md");

    for (int c = 0; c < 150; c++) begin
      fd = randInstr(1);
      dx = randInstr(0);
      if ($urandom_range(0, 1) == 1) dx[31:27] = OP_LW;
      br = ($urandom_range(0, 3) == 0);
      applyStimulus(fd, dx, br, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("random hazard", outs, {hazardModel(fd, dx, br), 2'b00, mdlTimeout});
    end

    applyStimulus(32'h0, mkR(3, 1, 2, 0, 6), 1'b0, 1'b0, 1'b0);
    checkOutput("reset-seq start pulse", ctrlMult, 1);
    applyStimulus(32'h0, mkR(3, 1, 2, 0, 6), 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0, mkR(3, 1, 2, 0, 6), 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("outputs forced low in reset", outs, 0);
    @(negedge clock);
    reset = 1'b0;
    mdlTimeout = 1'b0;
    inDX = 32'h0;
    #1 checkOutput("idle after mid-busy reset", outs, 0);
    leaks = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(32'h0, 32'h0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (outs != 0) leaks++;
    end
    checkOutput("no mdDone after abort", leaks, 0);
    runMd(1'b0, 4, 1'b0, "mul after reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
